// File: rtl/brom_arb_pkg.sv
// Shared widths, ID-width helper and delay-line tag type for the block-ROM arbiter.
package brom_arb_pkg;

  localparam int unsigned NREQ_DEF    = 2;
  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned ROM_LAT_DEF = 1;
  localparam int unsigned NREQ_MAX    = 8;

  // Requester ID width; a single requester still gets one bit.
  function automatic int unsigned idw(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned TAG_IDW = idw(NREQ_MAX);

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/brom_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid request at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            any_grant
);

  localparam int unsigned SW = IDW + 1;

  logic [SW-1:0] pos;

  // Walk offsets 0..NREQ-1 from ptr; explicit wrap keeps non-power-of-two NREQ exact.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    any_grant = 1'b0;
    pos       = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      pos = {1'b0, ptr} + SW'(k);
      if (pos >= SW'(NREQ)) pos = pos - SW'(NREQ);
      for (int j = 0; j < int'(NREQ); j++) begin
        if (!any_grant && req[j] && (pos == SW'(j))) begin
          grant[j]  = 1'b1;
          grant_id  = IDW'(j);
          any_grant = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/brom_arbiter.sv
// Round-robin sharing of one synchronous-read ROM; requester IDs ride a latency-matched
// tag pipeline so each read result is steered back to its issuer.
module brom_arbiter
  import brom_arb_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ROM_LAT = ROM_LAT_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]      resp_data,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [DATA_W-1:0]      rom_data
);

  localparam int unsigned IDW = idw(NREQ);

  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    ptr_next;
  logic [IDW:0]      id_inc;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_id;
  logic              any_grant;
  logic              fire;
  logic [ADDR_W-1:0] sel_addr;
  logic [NREQ-1:0]   resp_onehot;
  tag_t              tag_in;
  tag_t              tag_last;
  tag_t              tag_q [ROM_LAT];

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_id  (grant_id),
    .any_grant (any_grant)
  );

  assign req_ready = reset ? '0 : grant;
  assign fire      = any_grant & ~reset;
  assign tag_last  = tag_q[ROM_LAT-1];

  // Address of the granted requester plus next pointer and issue tag.
  always_comb begin
    sel_addr = '0;
    for (int j = 0; j < int'(NREQ); j++) begin
      if (grant[j]) sel_addr = req_addr[j*ADDR_W +: ADDR_W];
    end
    id_inc       = {1'b0, grant_id} + (IDW+1)'(1);
    ptr_next     = (id_inc == (IDW+1)'(NREQ)) ? '0 : id_inc[IDW-1:0];
    tag_in.valid = fire;
    tag_in.id    = TAG_IDW'(grant_id);
  end

  // Decode the retiring tag into a one-hot response strobe.
  always_comb begin
    resp_onehot = '0;
    for (int j = 0; j < int'(NREQ); j++) begin
      if (tag_last.valid && (tag_last.id == TAG_IDW'(j))) resp_onehot[j] = 1'b1;
    end
  end

  // The response register is the final delay-line stage and samples rom_data there.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr        <= '0;
      rom_addr   <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      for (int s = 0; s < int'(ROM_LAT); s++) tag_q[s] <= '0;
    end else begin
      if (fire) begin
        ptr      <= ptr_next;
        rom_addr <= sel_addr;
      end
      tag_q[0] <= tag_in;
      for (int s = 1; s < int'(ROM_LAT); s++) tag_q[s] <= tag_q[s-1];
      resp_valid <= resp_onehot;
      if (tag_last.valid) resp_data <= rom_data;
    end
  end

endmodule

// File: tb/tb_brom_arbiter.sv
// Bench for brom_arbiter: three instances (NREQ=2/LAT=1, NREQ=3/LAT=1, NREQ=2/LAT=3) checked
// against a transaction-level model of grants and expected responses.
module tb_brom_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst [3];
  logic [2:0] rv  [3];
  logic [23:0] ra [3];

  wire [1:0] rr0, rsv0, rr2, rsv2;
  wire [2:0] rr1, rsv1;
  wire [7:0] rd0, rd1, rd2, rom_a0, rom_a1, rom_a2;
  logic [7:0] rom_d2_p1, rom_d2_p2;
  wire [7:0] rom_d0 = rom_a0 ^ 8'hA5;
  wire [7:0] rom_d1 = rom_a1 ^ 8'hA5;
  wire [7:0] rom_d2 = rom_d2_p2 ^ 8'hA5;

  // Three-cycle ROM: two extra register stages after the address register.
  always @(posedge clock) begin
    rom_d2_p1 <= rom_a2;
    rom_d2_p2 <= rom_d2_p1;
  end

  brom_arbiter #(.NREQ(2), .ADDR_W(8), .DATA_W(8), .ROM_LAT(1)) u_dut0 (
    .clock(clock), .reset(rst[0]), .req_valid(rv[0][1:0]), .req_addr(ra[0][15:0]),
    .req_ready(rr0), .resp_valid(rsv0), .resp_data(rd0), .rom_addr(rom_a0), .rom_data(rom_d0));

  brom_arbiter #(.NREQ(3), .ADDR_W(8), .DATA_W(8), .ROM_LAT(1)) u_dut1 (
    .clock(clock), .reset(rst[1]), .req_valid(rv[1]), .req_addr(ra[1]),
    .req_ready(rr1), .resp_valid(rsv1), .resp_data(rd1), .rom_addr(rom_a1), .rom_data(rom_d1));

  brom_arbiter #(.NREQ(2), .ADDR_W(8), .DATA_W(8), .ROM_LAT(3)) u_dut2 (
    .clock(clock), .reset(rst[2]), .req_valid(rv[2][1:0]), .req_addr(ra[2][15:0]),
    .req_ready(rr2), .resp_valid(rsv2), .resp_data(rd2), .rom_addr(rom_a2), .rom_data(rom_d2));

  typedef struct {
    int         k;
    int         id;
    int         due;
    logic [7:0] data;
  } exp_t;

  exp_t       q[$];
  int         mptr [3];
  int         mcyc [3];
  logic [7:0] mra  [3];
  logic [7:0] mdata[3];
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic int nreq_of(input int k);
    return (k == 1) ? 3 : 2;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 2) ? 3 : 1;
  endfunction

  function automatic logic [2:0] get_ready(input int k);
    case (k)
      0:       return {1'b0, rr0};
      1:       return rr1;
      default: return {1'b0, rr2};
    endcase
  endfunction

  function automatic logic [2:0] get_rv(input int k);
    case (k)
      0:       return {1'b0, rsv0};
      1:       return rsv1;
      default: return {1'b0, rsv2};
    endcase
  endfunction

  function automatic logic [7:0] get_rd(input int k);
    case (k)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  function automatic logic [7:0] get_ra(input int k);
    case (k)
      0:       return rom_a0;
      1:       return rom_a1;
      default: return rom_a2;
    endcase
  endfunction

  // One clock cycle on instance k, entered and left at a falling edge. Returns granted id or -1.
  task automatic step(input int k, input logic r, input logic [2:0] v, input logic [23:0] a,
                      output int g);
    int         n;
    int         hit;
    int         idx;
    logic [2:0] exp_v;
    logic [2:0] exp_rdy;
    logic [7:0] addr;
    n = nreq_of(k);
    hit = -1;
    exp_v = 3'b000;
    foreach (q[i]) if (hit < 0 && q[i].k == k && q[i].due == mcyc[k]) hit = i;
    if (hit >= 0) begin
      exp_v    = 3'(1 << q[hit].id);
      mdata[k] = q[hit].data;
      q.delete(hit);
    end
    n_checks++;
    if (get_rv(k) !== exp_v) begin
      n_fail++;
      $display("FAIL resp_valid inst%0d cyc%0d: got %b exp %b", k, mcyc[k], get_rv(k), exp_v);
    end
    n_checks++;
    if (get_rd(k) !== mdata[k]) begin
      n_fail++;
      $display("FAIL resp_data inst%0d cyc%0d: got %h exp %h", k, mcyc[k], get_rd(k), mdata[k]);
    end
    n_checks++;
    if (get_ra(k) !== mra[k]) begin
      n_fail++;
      $display("FAIL rom_addr inst%0d cyc%0d: got %h exp %h", k, mcyc[k], get_ra(k), mra[k]);
    end

    rst[k] = r;
    rv[k]  = v;
    ra[k]  = a;
    #1;
    g = -1;
    if (!r) begin
      for (int j = 0; j < n; j++) begin
        idx = (mptr[k] + j) % n;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
    n_checks++;
    if (get_ready(k) !== exp_rdy) begin
      n_fail++;
      $display("FAIL req_ready inst%0d cyc%0d: got %b exp %b", k, mcyc[k], get_ready(k), exp_rdy);
    end

    @(posedge clock);
    if (r) begin
      for (int i = q.size() - 1; i >= 0; i--) if (q[i].k == k) q.delete(i);
      mptr[k]  = 0;
      mra[k]   = 8'h00;
      mdata[k] = 8'h00;
    end else if (g >= 0) begin
      addr    = a[g*8 +: 8];
      mptr[k] = (g + 1) % n;
      mra[k]  = addr;
      q.push_back('{k: k, id: g, due: mcyc[k] + lat_of(k) + 1, data: addr ^ 8'hA5});
    end
    mcyc[k]++;
    @(negedge clock);
  endtask

  task automatic idle(input int k, input int cycles);
    int g;
    for (int c = 0; c < cycles; c++) step(k, 1'b0, 3'b000, 24'h0, g);
  endtask

  task automatic test_reset();
    int g;
    for (int k = 0; k < 3; k++) begin
      step(k, 1'b1, 3'b111, 24'h332211, g);
      idle(k, 10);
    end
  endtask

  task automatic test_stream();
    int g;
    for (int i = 0; i < 16; i++) begin
      step(0, 1'b0, 3'b001, {16'h0, 8'(i)}, g);
      n_checks++;
      if (g != 0) begin
        n_fail++;
        $display("FAIL stream_grant beat%0d: got %0d exp 0", i, g);
      end
    end
    idle(0, 4);
  endtask

  task automatic test_contention();
    int g;
    int prev;
    prev = -1;
    for (int i = 0; i < 8; i++) begin
      step(0, 1'b0, 3'b011, 24'h002010, g);
      if (prev >= 0) begin
        n_checks++;
        if (g != 1 - prev) begin
          n_fail++;
          $display("FAIL contention_alt beat%0d: got %0d exp %0d", i, g, 1 - prev);
        end
      end
      prev = g;
    end
    idle(0, 4);
  endtask

  task automatic test_fairness();
    int g;
    int want [5];
    want = '{2, 0, 1, 2, 0};
    idle(1, 5);
    step(1, 1'b0, 3'b100, 24'h302010, g);
    n_checks++;
    if (g != want[0]) begin
      n_fail++;
      $display("FAIL fair_order beat0: got %0d exp %0d", g, want[0]);
    end
    for (int i = 1; i < 5; i++) begin
      step(1, 1'b0, 3'b111, 24'h302010, g);
      n_checks++;
      if (g != want[i]) begin
        n_fail++;
        $display("FAIL fair_order beat%0d: got %0d exp %0d", i, g, want[i]);
      end
    end
    idle(1, 4);
  endtask

  task automatic test_reset_midflight();
    int g;
    step(0, 1'b0, 3'b010, 24'h004400, g);
    step(0, 1'b1, 3'b000, 24'h0, g);
    step(0, 1'b0, 3'b011, 24'h005566, g);
    n_checks++;
    if (g != 0) begin
      n_fail++;
      $display("FAIL ptr_after_reset: got grant %0d exp 0", g);
    end
    idle(0, 5);
  endtask

  task automatic test_latency();
    int g;
    idle(2, 3);
    step(2, 1'b0, 3'b010, 24'h00C300, g);
    idle(2, 8);
    step(2, 1'b0, 3'b011, 24'h007F01, g);
    step(2, 1'b0, 3'b011, 24'h007F01, g);
    idle(2, 8);
  endtask

  task automatic test_random(input int k);
    int         n;
    int         g;
    logic       r;
    logic [2:0] pv;
    logic [7:0] pa [3];
    n  = nreq_of(k);
    pv = 3'b000;
    pa = '{8'h00, 8'h00, 8'h00};
    for (int c = 0; c < 120; c++) begin
      for (int i = 0; i < n; i++) begin
        if (!pv[i] && ($urandom_range(0, 1) == 1)) begin
          pv[i] = 1'b1;
          pa[i] = 8'($urandom);
        end
      end
      r = ($urandom_range(0, 39) == 0);
      step(k, r, pv, {pa[2], pa[1], pa[0]}, g);
      if (g >= 0) pv[g] = 1'b0;
    end
    for (int c = 0; c < 10 && pv != 3'b000; c++) begin
      step(k, 1'b0, pv, {pa[2], pa[1], pa[0]}, g);
      if (g >= 0) pv[g] = 1'b0;
    end
    idle(k, 6);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k]   = 1'b1;
      rv[k]    = 3'b000;
      ra[k]    = 24'h0;
      mptr[k]  = 0;
      mcyc[k]  = 0;
      mra[k]   = 8'h00;
      mdata[k] = 8'h00;
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    test_reset();
    test_stream();
    test_contention();
    test_fairness();
    test_reset_midflight();
    test_latency();
    for (int k = 0; k < 3; k++) test_random(k);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/brom_arbiter.md
Name: brom_arbiter

Overview:
- Shares one synchronous-read block ROM between NREQ requesters.
- Each requester uses a valid/ready request channel (address) and a valid-only response channel (data).
- Grants at most one request per cycle, round-robin, and drives the ROM address register.
- Carries the requester ID through a delay line matched to the ROM read latency, so each response is routed back to the requester that issued it.

Parameters:
- NREQ, 2, number of requesters (2..8).
- ADDR_W, 8, ROM address width.
- DATA_W, 8, ROM data width.
- ROM_LAT, 1, cycles from rom_addr change to valid rom_data (1..4).

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_ready  out  NREQ  one-hot grant; handshake is req_valid[i] & req_ready[i].
- resp_valid  out  NREQ  one-hot response strobe, one cycle wide.
- resp_data  out  DATA_W  read data, shared by all requesters; qualified by resp_valid.
- rom_addr  out  ADDR_W  registered address to the ROM.
- rom_data  in  DATA_W  ROM output.

Behaviour:
- Reset values:
  - rom_addr=0, resp_valid=0, resp_data=0.
  - Round-robin pointer ptr=0.
  - Tag pipeline valid bits all 0.
  - req_ready is combinational and reads 0 while reset is high.
- Reset mid-operation: all in-flight reads are dropped and no resp_valid fires for them afterwards.
- Arbitration (combinational, same cycle):
  - Scan requesters ptr, ptr+1, ... modulo NREQ.
  - The first one with req_valid high gets req_ready=1; all others get 0.
  - With no valid requests, req_ready=0.
  - req_ready never depends on the granted requester's own ready (no loops).
- Pointer update:
  - On a handshake by requester g, ptr <= (g+1) mod NREQ.
  - With no handshake, ptr holds.
- Issue:
  - Handshake in cycle t: rom_addr <= req_addr[g] at edge t, and a tag {valid=1, id=g} enters stage 0 of the delay line.
  - With no handshake, rom_addr holds its value and a tag with valid=0 enters.
- Delay line:
  - ROM_LAT+1 stages total: 1 issue stage plus ROM_LAT ROM stages.
  - rom_data is sampled when the tag reaches the last stage.
- Response:
  - resp_data and resp_valid are registered.
  - Handshake at cycle t gives resp_valid[g]=1 with resp_data=ROM[addr] in cycle t+ROM_LAT+1; for ROM_LAT=1 that is t+2.
  - resp_data holds its last value when no response is due.
- Throughput:
  - One request per cycle, sustained; fully pipelined, no bubbles.
  - Responses return in handshake order.
- Requester obligations:
  - No response backpressure; a requester must accept the response in the cycle resp_valid fires.
  - A requester may hold req_valid and change req_addr only after its handshake.
- Fairness:
  - With every requester valid continuously, grants cycle 0,1,...,NREQ-1,0,...
  - No requester waits more than NREQ-1 cycles once its req_valid is high.
- Width rules:
  - ID width is clog2(NREQ), minimum 1.
  - ptr wraps modulo NREQ; non-power-of-two NREQ is handled by explicit compare-and-reset, not bit truncation.
- Simultaneous events: a handshake in the same cycle as a response delivery to the same requester is legal; both occur.

Decomposition:
- Package brom_arb_pkg holds:
  - Default widths.
  - Function idw(n) = max(1, clog2(n)).
  - Packed tag struct {logic valid; logic [IDW-1:0] id}.
- Sub-module rr_arbiter:
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, encoded grant id, any_grant.
  - Purely combinational; ptr register stays in brom_arbiter.

Test Plan:
1. Reset then idle: reset high for 3 cycles, no req_valid → rom_addr=0, resp_valid=0, req_ready=0 every cycle for 10 cycles.
2. Single requester, ROM model data=addr^8'hA5, ROM_LAT=1, requester 0 streams addr 0x00..0x0F back-to-back:
   - req_ready[0]=1 every cycle.
   - resp_valid[0] starts exactly 2 cycles after the first handshake.
   - resp_data = 0xA5, 0xA4, 0xA7, ..., 0xAA in order.
3. Contention, NREQ=2:
   - Stimulus: both requesters valid continuously, req0 addr=0x10, req1 addr=0x20.
   - Grants alternate 0,1,0,1.
   - resp_valid alternates 01,10 with data 0xB5/0x85.
4. Pointer fairness, NREQ=3:
   - Stimulus: only req2 valid at cycle 5, then all three valid from cycle 6.
   - Grant order is 2,0,1,2,0.
5. Reset mid-flight: assert reset in the cycle after a handshake by req1 → no resp_valid for that request; ptr=0 after release.
6. Latency sweep: ROM_LAT=3, single handshake at cycle t → resp_valid exactly at t+4 and nowhere else.
